// File: rtl/clock_pattern_gen.sv
// clock_pattern_gen
//   Generates a programmable clock pattern (CLK_IN) and a gate value
//   (COND_IN) with one-cycle strobes that feed a downstream clock-maker.
//   CLK_IN is high for len_high cycles and low for len_low cycles.
//   A length of 0 is treated as 1. New lengths go through a one-entry
//   shadow and take effect only at a period boundary. A gate request is
//   held until CLK_IN is low and is then issued glitch-free.
//
// Parameters
//   CNT_W      width of the phase counter and the length fields
//   INIT_HIGH  high-phase length after reset
//   INIT_LOW   low-phase length after reset
//   INIT_GATE  COND_IN value after reset
//
// Ports
//   CLK          clock, rising edge active
//   RST          asynchronous active-high reset
//   RUN          level; enables pattern generation
//   CFG_HIGH     requested high-phase length
//   CFG_LOW      requested low-phase length
//   CFG_EN       config load strobe; taken only while CFG_RDY=1
//   CFG_RDY      config shadow empty
//   GATE_REQ     requested gate value
//   GATE_REQ_EN  gate request strobe
//   CLK_IN       generated clock value
//   CLK_IN_EN    one-cycle pulse on every CLK_IN toggle
//   COND_IN      gate value
//   COND_IN_EN   one-cycle pulse on every gate update
//   BUSY         pattern active (HIGH or LOW phase)
//   EDGE_CNT     rising-toggle count, 32-bit wrapping
//                (present only with CLKGEN_EDGE_COUNT_EN)
//
// Optional feature macro: CLKGEN_EDGE_COUNT_EN

module clock_pattern_gen #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned INIT_HIGH = 1,
  parameter int unsigned INIT_LOW  = 1,
  parameter logic        INIT_GATE = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic [CNT_W-1:0] CFG_HIGH,
  input  logic [CNT_W-1:0] CFG_LOW,
  input  logic             CFG_EN,
  output logic             CFG_RDY,
  input  logic             GATE_REQ,
  input  logic             GATE_REQ_EN,
  output logic             CLK_IN,
  output logic             CLK_IN_EN,
  output logic             COND_IN,
  output logic             COND_IN_EN,
  output logic             BUSY
`ifdef CLKGEN_EDGE_COUNT_EN
  ,
  output logic [31:0]      EDGE_CNT
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] INIT_HIGH_V = CNT_W'(INIT_HIGH);
  localparam logic [CNT_W-1:0] INIT_LOW_V  = CNT_W'(INIT_LOW);

  // Counter preload for a phase of 'len' cycles; 0 behaves as 1.
  function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : (len - CNT_W'(1));
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_high_q, len_high_d;
  logic [CNT_W-1:0] len_low_q, len_low_d;
  logic [CNT_W-1:0] shd_high_q, shd_high_d;
  logic [CNT_W-1:0] shd_low_q, shd_low_d;
  logic             shd_vld_q, shd_vld_d;
  logic             cfg_rdy_q, cfg_rdy_d;
  logic             clk_in_q, clk_in_d;
  logic             clk_in_en_q, clk_in_en_d;
  logic             cond_in_q, cond_in_d;
  logic             cond_in_en_q, cond_in_en_d;
  logic             gate_pend_q, gate_pend_d;
  logic             gate_val_q, gate_val_d;
  logic             busy_q, busy_d;

  logic             period_start;
  logic             cfg_apply;
  logic             cfg_take;
  logic             gate_issue;
  logic [CNT_W-1:0] eff_high;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_high_d   = len_high_q;
    len_low_d    = len_low_q;
    shd_high_d   = shd_high_q;
    shd_low_d    = shd_low_q;
    shd_vld_d    = shd_vld_q;
    cfg_rdy_d    = cfg_rdy_q;
    clk_in_d     = clk_in_q;
    clk_in_en_d  = 1'b0;
    cond_in_d    = cond_in_q;
    cond_in_en_d = 1'b0;
    gate_pend_d  = gate_pend_q;
    gate_val_d   = gate_val_q;
    period_start = 1'b0;
    cfg_apply    = 1'b0;
    cfg_take     = 1'b0;
    gate_issue   = 1'b0;
    eff_high     = len_high_q;

    case (state_q)
      ST_IDLE: begin
        if (RUN) period_start = 1'b1;
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d     = ST_LOW;
          clk_in_d    = 1'b0;
          clk_in_en_d = 1'b1;
          cnt_d       = phase_load(len_low_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          // End of period: either start the next one back-to-back or park.
          if (RUN) period_start = 1'b1;
          else     state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A pending shadow lands at a period start, or right away while idle.
    cfg_apply = shd_vld_q && (period_start || (state_q == ST_IDLE));
    if (cfg_apply) begin
      len_high_d = shd_high_q;
      len_low_d  = shd_low_q;
      shd_vld_d  = 1'b0;
      eff_high   = shd_high_q;
    end

    if (period_start) begin
      state_d     = ST_HIGH;
      clk_in_d    = 1'b1;
      clk_in_en_d = 1'b1;
      cnt_d       = phase_load(eff_high);
    end

    // CFG_RDY lags the shadow by one cycle, so it only rises the cycle
    // after the shadow has been applied; a take can never meet an apply.
    cfg_take = CFG_EN && cfg_rdy_q;
    if (cfg_take) begin
      shd_high_d = CFG_HIGH;
      shd_low_d  = CFG_LOW;
      shd_vld_d  = 1'b1;
      cfg_rdy_d  = 1'b0;
    end else begin
      cfg_rdy_d  = !shd_vld_q;
    end

    // Gate changes only while the next CLK_IN value is low, so a rising
    // toggle always wins and the update waits for the next low cycle.
    gate_issue = gate_pend_q && !clk_in_d;
    if (gate_issue && (gate_val_q != cond_in_q)) begin
      cond_in_d    = gate_val_q;
      cond_in_en_d = 1'b1;
    end
    if (GATE_REQ_EN) begin
      gate_pend_d = 1'b1;
      gate_val_d  = GATE_REQ;
    end else if (gate_issue) begin
      gate_pend_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      len_high_q   <= INIT_HIGH_V;
      len_low_q    <= INIT_LOW_V;
      shd_high_q   <= '0;
      shd_low_q    <= '0;
      shd_vld_q    <= 1'b0;
      cfg_rdy_q    <= 1'b1;
      clk_in_q     <= 1'b0;
      clk_in_en_q  <= 1'b0;
      cond_in_q    <= INIT_GATE;
      cond_in_en_q <= 1'b0;
      gate_pend_q  <= 1'b0;
      gate_val_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_high_q   <= len_high_d;
      len_low_q    <= len_low_d;
      shd_high_q   <= shd_high_d;
      shd_low_q    <= shd_low_d;
      shd_vld_q    <= shd_vld_d;
      cfg_rdy_q    <= cfg_rdy_d;
      clk_in_q     <= clk_in_d;
      clk_in_en_q  <= clk_in_en_d;
      cond_in_q    <= cond_in_d;
      cond_in_en_q <= cond_in_en_d;
      gate_pend_q  <= gate_pend_d;
      gate_val_q   <= gate_val_d;
      busy_q       <= busy_d;
    end
  end

  assign CFG_RDY    = cfg_rdy_q;
  assign CLK_IN     = clk_in_q;
  assign CLK_IN_EN  = clk_in_en_q;
  assign COND_IN    = cond_in_q;
  assign COND_IN_EN = cond_in_en_q;
  assign BUSY       = busy_q;

`ifdef CLKGEN_EDGE_COUNT_EN
  logic [31:0] edge_cnt_q, edge_cnt_d;

  // Every period start is a rising toggle of CLK_IN.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (period_start) edge_cnt_d = edge_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) edge_cnt_q <= '0;
    else     edge_cnt_q <= edge_cnt_d;
  end

  assign EDGE_CNT = edge_cnt_q;
`endif

endmodule
